sa_sequencer: RTL and testbench
===============================

# sa_sequencer

Parametrised instruction sequencer for the systolic-array TPU. It accepts instructions over a valid/ready handshake and decodes the opcode. For each instruction it drives a fixed-length burst of unified/weight-buffer and MMU strobes with auto-incrementing addresses, and assembles byte-serial write payloads into one ARRAY_N-lane word. It sits between the host instruction port and the buffers/MMU, and signals completion with a one-cycle `done` pulse.

## Interface
- ARRAY_N, 16, systolic array dimension; number of lanes, rows and columns.
- DATA_BITS, 8, lane width; must equal OPERAND_BITS.
- OPCODE_BITS, 8, opcode field width, instruction[ISA-1:OPERAND_BITS].
- OPERAND_BITS, 8, address/data operand field width, instruction[OPERAND_BITS-1:0].
- LOAD_DATA_CYCLES, 4, burst length of LOAD_DATA.
- Clock and reset (already decided): one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- instruction  in  OPCODE_BITS+OPERAND_BITS  opcode and operand.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  sequencer can accept.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-opcode pulse.
- load_data, load_weight, mat_mul, write_result, write_data, write_weight  out  1 each  unit strobes.
- addra  out  OPERAND_BITS  buffer read address.
- addrb  out  OPERAND_BITS  buffer write address.
- dout  out  ARRAY_N*DATA_BITS  assembled write word; lane 0 occupies the LSBs.

## Operation
- Opcodes:
  - NOP = 0x00.
  - LOAD_DATA = 0x01.
  - LOAD_WEIGHT = 0x02.
  - MAT_MUL = 0x03.
  - WRITE_RESULT = 0x04.
  - WRITE_DATA = 0x05.
  - WRITE_WEIGHT = 0x06.
  - Any other value is illegal.
- States: IDLE, BURST, GATHER, COMMIT.
- Accept occurs on `inst_valid && inst_ready`. `inst_ready` = (state==IDLE) || (state==GATHER).
- IDLE behaviour on accept:
  - NOP: no action and no `done`.
  - Illegal opcode: `err`=1 for the next cycle, then the sequencer stays in IDLE.
  - LOAD_DATA, LOAD_WEIGHT, MAT_MUL, WRITE_RESULT: latch the opcode and base = operand, clear cnt, go to BURST.
  - WRITE_DATA, WRITE_WEIGHT: latch the opcode and base, clear cnt and the lane buffer, go to GATHER.
- BURST lengths (D):
  - LOAD_DATA: D = LOAD_DATA_CYCLES.
  - Other burst ops: D = ARRAY_N.
- BURST outputs per cycle cnt = 0..D-1:
  - The op's strobe is 1.
  - LOAD_DATA and LOAD_WEIGHT: addra = base+cnt.
  - WRITE_RESULT: addrb = base+cnt.
  - MAT_MUL: both addresses are 0.
  - Address addition wraps modulo 2^OPERAND_BITS.
  - At cnt = D-1, `done`=1, then return to IDLE.
- GATHER:
  - Each accepted beat stores operand into lane cnt, then cnt increments.
  - The beat opcode field is ignored, including NOP and illegal values; it raises no `err`.
  - After beat ARRAY_N-1 is accepted, go to COMMIT.
- COMMIT (one cycle):
  - write_data or write_weight = 1.
  - addrb = base.
  - dout = assembled word.
  - `done` = 1.
  - Then go to IDLE.
- `dout` holds the last committed word until the next COMMIT.
- Counter width is $clog2(ARRAY_N+1).

## Timing
- All outputs are registered.
- Reset values: every output is 0 except inst_ready, which is 1.
  - Reset also clears state, cnt, base, lane buffer and dout.
- Latency: an instruction accepted at edge k drives its first strobe in cycle k+1.
  - A burst occupies cycles k+1..k+D.
  - The next accept is possible at edge k+D+1.
- WRITE_DATA/WRITE_WEIGHT: the header is accepted at edge k. With beats back-to-back from edge k+1, COMMIT falls in cycle k+ARRAY_N+1.
  - Valid gaps between beats stall GATHER indefinitely, with no timeout.
- `inst_valid` while `inst_ready`=0 is not accepted. The source holds the instruction stable.
- `done` and `err` are never simultaneous. `busy` is 0 in the cycle after `done`.
- Reset asserted mid-operation aborts immediately: strobes drop asynchronously, no `done` is issued, and the partial gather is discarded.
- The instruction is sampled only on accept; changes during BURST are ignored.

## Configuration
- SA_SEQ_PERF_EN defined:
  - Adds outputs perf_busy_cycles[31:0] (increments each cycle busy=1) and perf_inst_count[31:0] (increments on each `done`).
  - Both counters saturate at 0xFFFF_FFFF and are cleared by reset.
- SA_SEQ_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `sa_share`: opcode constants, state encoding, ISA width localparams.
- One natural sub-module, `sa_gather_buf`: lane buffer with clear, indexed byte write and a parallel word output.
- State register, counter, address adders and strobe decode live in the top module.

## Test plan
- Reset, then LOAD_WEIGHT with base 0xF0 (ARRAY_N=16) -> load_weight high 16 cycles, addra 0xF0..0xFF, `done` in cycle 16.
- LOAD_DATA with base 0xFE -> load_data high 4 cycles, addra 0xFE, 0xFF, 0x00, 0x01 (wrap); `done` on the 4th cycle.
- WRITE_DATA with base 0x20, then beats 0x00..0x0F with one idle gap after beat 7 -> single write_data pulse, addrb=0x20, dout=0x0F0E…0100, `done` coincident.
- Opcode 0x7F in IDLE -> `err` one cycle, no strobe, inst_ready remains 1. NOP -> no `done`.
- MAT_MUL held valid back-to-back twice -> two 16-cycle mat_mul bursts separated by exactly one idle cycle; `busy` low in that cycle.
- reset_n low at cnt=5 of WRITE_RESULT -> all strobes 0 immediately and dout=0; after release, a fresh WRITE_WEIGHT commits correctly. With SA_SEQ_PERF_EN, perf_inst_count counts only completed instructions.

Source files
------------

// File: rtl/sa_share_pkg.sv
// ---------------------------------------------------------------------------
// sa_share : definitions shared by the systolic-array instruction sequencer.
//
// Contents
//   - ISA field widths (defaults for the sequencer parameters)
//   - state_t : sequencer FSM encoding
//   - op_t    : decoded opcode, one code per legal ISA opcode plus OP_ILLEGAL
//   - helpers classifying decoded opcodes into burst / gather families
// ---------------------------------------------------------------------------
package sa_share;

    localparam int ISA_OPCODE_BITS  = 8;
    localparam int ISA_OPERAND_BITS = 8;

    // Opcodes 0..NUM_OPCODES-1 are legal; everything above is illegal.
    localparam int NUM_OPCODES = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_GATHER = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Encodings of the legal codes match the ISA opcode values.
    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_LOAD_DATA    = 3'd1,
        OP_LOAD_WEIGHT  = 3'd2,
        OP_MAT_MUL      = 3'd3,
        OP_WRITE_RESULT = 3'd4,
        OP_WRITE_DATA   = 3'd5,
        OP_WRITE_WEIGHT = 3'd6,
        OP_ILLEGAL      = 3'd7
    } op_t;

    function automatic logic is_burst_op(input op_t op);
        return (op == OP_LOAD_DATA) || (op == OP_LOAD_WEIGHT) ||
               (op == OP_MAT_MUL)   || (op == OP_WRITE_RESULT);
    endfunction

    function automatic logic is_gather_op(input op_t op);
        return (op == OP_WRITE_DATA) || (op == OP_WRITE_WEIGHT);
    endfunction

endpackage

// File: rtl/sa_gather_buf.sv
// ---------------------------------------------------------------------------
// sa_gather_buf : lane buffer that assembles byte-serial payload beats into
// one ARRAY_N-lane word.
//
// Ports
//   clk, reset_n : clock, asynchronous active-low reset (clears all lanes)
//   clr          : synchronous clear of every lane (takes priority)
//   wr_en        : write wr_data into lane wr_idx
//   wr_idx       : lane index
//   wr_data      : lane data
//   word         : all lanes in parallel, lane 0 in the LSBs
// ---------------------------------------------------------------------------
module sa_gather_buf #(
    parameter int ARRAY_N   = 16,
    parameter int DATA_BITS = 8,
    parameter int IDX_W     = $clog2(ARRAY_N + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_BITS-1:0]           wr_data,
    output logic [ARRAY_N*DATA_BITS-1:0]   word
);

    logic [DATA_BITS-1:0] lane_q [ARRAY_N];
    logic [DATA_BITS-1:0] lane_d [ARRAY_N];

    always_comb begin
        for (int i = 0; i < ARRAY_N; i++) begin
            lane_d[i] = lane_q[i];
            if (clr) begin
                lane_d[i] = '0;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                lane_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARRAY_N; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ARRAY_N; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    for (genvar g = 0; g < ARRAY_N; g++) begin : g_word
        assign word[g*DATA_BITS +: DATA_BITS] = lane_q[g];
    end

endmodule

// File: rtl/sa_sequencer.sv
// ---------------------------------------------------------------------------
// sa_sequencer : instruction sequencer for the systolic-array TPU.
//
// Accepts {opcode, operand} instructions over valid/ready, then either runs a
// fixed-length strobe burst with auto-incrementing address (LOAD_DATA,
// LOAD_WEIGHT, MAT_MUL, WRITE_RESULT) or gathers ARRAY_N payload beats into
// one word and commits it in a single cycle (WRITE_DATA, WRITE_WEIGHT).
// Every output is a flop; the output decode looks at the *next* state so
// strobes appear in the cycle right after the accepting edge.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   instruction    : {opcode[OPCODE_BITS], operand[OPERAND_BITS]}
//   inst_valid     : instruction present
//   inst_ready     : sequencer accepts this cycle (IDLE or GATHER)
//   busy           : not IDLE
//   done / err     : one-cycle completion / illegal-opcode pulses
//   load_data .. write_weight : unit strobes
//   addra / addrb  : buffer read / write address
//   dout           : last committed word, lane 0 in the LSBs
//   perf_busy_cycles, perf_inst_count : saturating counters, present only
//                    when the macro SA_SEQ_PERF_EN is defined
// ---------------------------------------------------------------------------
module sa_sequencer
    import sa_share::*;
#(
    parameter int ARRAY_N          = 16,
    parameter int DATA_BITS        = 8,
    parameter int OPCODE_BITS      = ISA_OPCODE_BITS,
    parameter int OPERAND_BITS     = ISA_OPERAND_BITS,
    parameter int LOAD_DATA_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [OPCODE_BITS+OPERAND_BITS-1:0] instruction,
    input  logic                                inst_valid,
    output logic                                inst_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                load_data,
    output logic                                load_weight,
    output logic                                mat_mul,
    output logic                                write_result,
    output logic                                write_data,
    output logic                                write_weight,
    output logic [OPERAND_BITS-1:0]             addra,
    output logic [OPERAND_BITS-1:0]             addrb,
    output logic [ARRAY_N*DATA_BITS-1:0]        dout
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]                         perf_busy_cycles,
    output logic [31:0]                         perf_inst_count
`endif
);

    localparam int CNT_W  = $clog2(ARRAY_N + 1);
    localparam int WORD_W = ARRAY_N * DATA_BITS;

    function automatic op_t decode_op(input logic [OPCODE_BITS-1:0] code);
        if (code < OPCODE_BITS'(NUM_OPCODES)) begin
            return op_t'(code[2:0]);
        end
        return OP_ILLEGAL;
    endfunction

    // Index of the final burst cycle, where done is raised.
    function automatic logic [CNT_W-1:0] last_idx(input op_t op);
        if (op == OP_LOAD_DATA) begin
            return CNT_W'(LOAD_DATA_CYCLES - 1);
        end
        return CNT_W'(ARRAY_N - 1);
    endfunction

    logic [OPCODE_BITS-1:0]  opcode_f;
    logic [OPERAND_BITS-1:0] operand_f;
    op_t                     inst_op;
    logic                    accept;

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [OPERAND_BITS-1:0] base_q, base_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    inst_ready_q, inst_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    load_data_q, load_data_d;
    logic                    load_weight_q, load_weight_d;
    logic                    mat_mul_q, mat_mul_d;
    logic                    write_result_q, write_result_d;
    logic                    write_data_q, write_data_d;
    logic                    write_weight_q, write_weight_d;
    logic [OPERAND_BITS-1:0] addra_q, addra_d;
    logic [OPERAND_BITS-1:0] addrb_q, addrb_d;
    logic [WORD_W-1:0]       dout_q, dout_d;
    logic [OPERAND_BITS-1:0] burst_addr;

    logic                    buf_clr;
    logic                    buf_wr;
    logic [WORD_W-1:0]       buf_word;

    assign opcode_f  = instruction[OPCODE_BITS+OPERAND_BITS-1:OPERAND_BITS];
    assign operand_f = instruction[OPERAND_BITS-1:0];
    assign inst_op   = decode_op(opcode_f);
    assign accept    = inst_valid && inst_ready_q;

    sa_gather_buf #(
        .ARRAY_N   (ARRAY_N),
        .DATA_BITS (DATA_BITS),
        .IDX_W     (CNT_W)
    ) u_gather_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (cnt_q),
        .wr_data (DATA_BITS'(operand_f)),
        .word    (buf_word)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // NOP and illegal opcodes leave the FSM in IDLE.
                if (accept && (is_burst_op(inst_op) || is_gather_op(inst_op))) begin
                    op_d    = inst_op;
                    base_d  = operand_f;
                    cnt_d   = '0;
                    state_d = is_burst_op(inst_op) ? ST_BURST : ST_GATHER;
                    buf_clr = is_gather_op(inst_op);
                end
            end
            ST_BURST: begin
                if (cnt_q == last_idx(op_q)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GATHER: begin
                // Beat opcode is ignored: every accepted beat is payload.
                if (accept) begin
                    buf_wr = 1'b1;
                    if (cnt_q == CNT_W'(ARRAY_N - 1)) begin
                        state_d = ST_COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        load_data_d    = 1'b0;
        load_weight_d  = 1'b0;
        mat_mul_d      = 1'b0;
        write_result_d = 1'b0;
        write_data_d   = 1'b0;
        write_weight_d = 1'b0;
        addra_d        = '0;
        addrb_d        = '0;
        done_d         = 1'b0;
        dout_d         = dout_q;
        err_d          = (state_q == ST_IDLE) && accept && (inst_op == OP_ILLEGAL);
        inst_ready_d   = (state_d == ST_IDLE) || (state_d == ST_GATHER);
        busy_d         = (state_d != ST_IDLE);
        burst_addr     = base_d + OPERAND_BITS'(cnt_d);
        case (state_d)
            ST_BURST: begin
                done_d = (cnt_d == last_idx(op_d));
                case (op_d)
                    OP_LOAD_DATA: begin
                        load_data_d = 1'b1;
                        addra_d     = burst_addr;
                    end
                    OP_LOAD_WEIGHT: begin
                        load_weight_d = 1'b1;
                        addra_d       = burst_addr;
                    end
                    OP_MAT_MUL:      mat_mul_d = 1'b1;
                    OP_WRITE_RESULT: begin
                        write_result_d = 1'b1;
                        addrb_d        = burst_addr;
                    end
                    default: ;
                endcase
            end
            ST_COMMIT: begin
                // The last beat lands in the top lane this very edge, so it is
                // merged here rather than read back from the buffer.
                write_data_d   = (op_d == OP_WRITE_DATA);
                write_weight_d = (op_d == OP_WRITE_WEIGHT);
                addrb_d        = base_d;
                done_d         = 1'b1;
                dout_d         = buf_word;
                dout_d[WORD_W-1 -: DATA_BITS] = DATA_BITS'(operand_f);
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            load_data_q    <= 1'b0;
            load_weight_q  <= 1'b0;
            mat_mul_q      <= 1'b0;
            write_result_q <= 1'b0;
            write_data_q   <= 1'b0;
            write_weight_q <= 1'b0;
            addra_q        <= '0;
            addrb_q        <= '0;
            dout_q         <= '0;
        end else begin
            inst_ready_q   <= inst_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            load_data_q    <= load_data_d;
            load_weight_q  <= load_weight_d;
            mat_mul_q      <= mat_mul_d;
            write_result_q <= write_result_d;
            write_data_q   <= write_data_d;
            write_weight_q <= write_weight_d;
            addra_q        <= addra_d;
            addrb_q        <= addrb_d;
            dout_q         <= dout_d;
        end
    end

    assign inst_ready   = inst_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign load_data    = load_data_q;
    assign load_weight  = load_weight_q;
    assign mat_mul      = mat_mul_q;
    assign write_result = write_result_q;
    assign write_data   = write_data_q;
    assign write_weight = write_weight_q;
    assign addra        = addra_q;
    assign addrb        = addrb_q;
    assign dout         = dout_q;

`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles_q, perf_busy_cycles_d;
    logic [31:0] perf_inst_count_q, perf_inst_count_d;

    always_comb begin
        perf_busy_cycles_d = perf_busy_cycles_q;
        perf_inst_count_d  = perf_inst_count_q;
        if (busy_q && (perf_busy_cycles_q != 32'hFFFF_FFFF)) begin
            perf_busy_cycles_d = perf_busy_cycles_q + 32'd1;
        end
        if (done_q && (perf_inst_count_q != 32'hFFFF_FFFF)) begin
            perf_inst_count_d = perf_inst_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_cycles_q <= '0;
            perf_inst_count_q  <= '0;
        end else begin
            perf_busy_cycles_q <= perf_busy_cycles_d;
            perf_inst_count_q  <= perf_inst_count_d;
        end
    end

    assign perf_busy_cycles = perf_busy_cycles_q;
    assign perf_inst_count  = perf_inst_count_q;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_sequencer : self-checking bench for sa_sequencer (default parameters).
// Expected behaviour comes from a transaction-level model: for each issued
// instruction the bench derives the strobe/address/done sequence, or the
// assembled payload word, from the opcode rules.
// ---------------------------------------------------------------------------
module tb_sa_sequencer;

    localparam int N = 16;
    localparam int W = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   instruction = '0;
    logic          inst_valid = 1'b0;
    logic          inst_ready, busy, done, err;
    logic          load_data, load_weight, mat_mul, write_result, write_data, write_weight;
    logic [7:0]    addra, addrb;
    logic [W-1:0]  dout;
`ifdef SA_SEQ_PERF_EN
    logic [31:0]   perf_busy_cycles, perf_inst_count;
`endif

    sa_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instruction  (instruction),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .load_data    (load_data),
        .load_weight  (load_weight),
        .mat_mul      (mat_mul),
        .write_result (write_result),
        .write_data   (write_data),
        .write_weight (write_weight),
        .addra        (addra),
        .addrb        (addrb),
        .dout         (dout)
`ifdef SA_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_inst_count  (perf_inst_count)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_done_exp = 0;
    logic [W-1:0] exp_dout = '0;
    logic [7:0]   beat_data [N];
    int           beat_gap [N];

    logic [5:0] strb;
    assign strb = {load_data, load_weight, mat_mul, write_result, write_data, write_weight};

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [7:0] operand);
        instruction = {op, operand};
        inst_valid  = 1'b1;
    endtask

    // One strobe bit per opcode 1..6, ordered load_data (MSB) .. write_weight.
    function automatic logic [5:0] op_mask(input int op);
        if (op >= 1 && op <= 6) return 6'(1 << (6 - op));
        return 6'd0;
    endfunction

    // {busy, inst_ready, strobes, done, err}
    task automatic expect_idle(input string tag);
        check(tag, {busy, inst_ready, strb, done, err}, {1'b0, 1'b1, 6'd0, 1'b0, 1'b0});
    endtask

    task automatic expect_burst(input int op, input logic [7:0] base);
        int d;
        logic [7:0] a;
        d = (op == 1) ? 4 : N;
        for (int i = 0; i < d; i++) begin
            a = base + 8'(i);
            check("burst_strobe", strb, op_mask(op));
            check("burst_addra", addra, (op == 1 || op == 2) ? a : 8'd0);
            check("burst_addrb", addrb, (op == 4) ? a : 8'd0);
            check("burst_ctl", {done, busy, inst_ready, err}, {(i == d - 1), 1'b1, 1'b0, 1'b0});
            step();
        end
        n_done_exp++;
    endtask

    task automatic run_gather(input int op, input logic [7:0] base);
        logic [W-1:0] word;
        word = '0;
        drive(8'(op), base);
        step();
        check("gather_hdr", {busy, inst_ready, strb, done, err}, {1'b1, 1'b1, 6'd0, 1'b0, 1'b0});
        check("gather_hold", dout, exp_dout);
        for (int b = 0; b < N; b++) begin
            for (int g = 0; g < beat_gap[b]; g++) begin
                inst_valid = 1'b0;
                step();
                check("gather_gap", {busy, inst_ready, strb, done}, {1'b1, 1'b1, 6'd0, 1'b0});
            end
            drive(8'($urandom_range(0, 255)), beat_data[b]);
            word[b*8 +: 8] = beat_data[b];
            step();
            if (b < N - 1)
                check("gather_beat", {busy, inst_ready, strb, done, err}, {1'b1, 1'b1, 6'd0, 1'b0, 1'b0});
        end
        inst_valid = 1'b0;
        check("commit_strobe", strb, op_mask(op));
        check("commit_addr", {addra, addrb}, {8'd0, base});
        check("commit_dout", dout, word);
        check("commit_ctl", {done, busy, inst_ready, err}, {1'b1, 1'b1, 1'b0, 1'b0});
        exp_dout = word;
        n_done_exp++;
        step();
        expect_idle("commit_after");
        check("dout_hold", dout, exp_dout);
    endtask

    task automatic run_inst(input logic [7:0] op, input logic [7:0] base);
        if (op >= 8'd1 && op <= 8'd4) begin
            drive(op, base);
            step();
            inst_valid = 1'b0;
            expect_burst(int'(op), base);
            expect_idle("burst_after");
        end else if (op == 8'd5 || op == 8'd6) begin
            for (int i = 0; i < N; i++) begin
                beat_data[i] = 8'($urandom_range(0, 255));
                beat_gap[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            run_gather(int'(op), base);
        end else if (op == 8'd0) begin
            drive(op, base);
            step();
            inst_valid = 1'b0;
            expect_idle("nop");
            step();
            expect_idle("nop_after");
        end else begin
            drive(op, base);
            step();
            inst_valid = 1'b0;
            check("illegal_err", {err, busy, inst_ready, strb, done}, {1'b1, 1'b0, 1'b1, 6'd0, 1'b0});
            step();
            expect_idle("illegal_after");
        end
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] base;

        // Reset state
        #12;
        expect_idle("reset_ctl");
        check("reset_data", {addra, addrb, dout}, '0);
        reset_n = 1'b1;
        step();
        expect_idle("post_reset");

        // Directed scenarios
        run_inst(8'h02, 8'hF0);
        run_inst(8'h01, 8'hFE);
        for (int i = 0; i < N; i++) begin
            beat_data[i] = 8'(i);
            beat_gap[i]  = (i == 8) ? 1 : 0;
        end
        run_gather(5, 8'h20);
        check("wd_word", dout, 128'h0F0E0D0C0B0A09080706050403020100);
        run_inst(8'h7F, 8'h00);
        run_inst(8'h00, 8'h55);

        // MAT_MUL held valid: two bursts with one idle cycle between
        drive(8'h03, 8'h11);
        step();
        expect_burst(3, 8'h11);
        check("mm_gap", {busy, inst_ready, strb, done}, {1'b0, 1'b1, 6'd0, 1'b0});
        step();
        inst_valid = 1'b0;
        expect_burst(3, 8'h11);
        expect_idle("mm_after");

        // Randomized instruction mix
        for (int t = 0; t < 14; t++) begin
            op   = 8'($urandom_range(0, 7));
            if (op == 8'd7) op = 8'($urandom_range(7, 255));
            base = 8'($urandom_range(0, 255));
            run_inst(op, base);
        end

`ifdef SA_SEQ_PERF_EN
        check("perf_inst", perf_inst_count, n_done_exp);
`endif

        // Reset in the middle of WRITE_RESULT at cnt=5
        base = 8'($urandom_range(0, 255));
        drive(8'h04, base);
        step();
        inst_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("wr_pre_strobe", {strb, addrb}, {op_mask(4), 8'(base + 8'(i))});
            if (i < 5) step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        expect_idle("abort_ctl");
        check("abort_data", {addra, addrb, dout}, '0);
        exp_dout   = '0;
        n_done_exp = 0;
        @(posedge clk);
        #2;
        expect_idle("abort_hold");
        reset_n = 1'b1;
        step();

        // Fresh WRITE_WEIGHT after the abort, no beat gaps
        for (int i = 0; i < N; i++) begin
            beat_data[i] = 8'($urandom_range(0, 255));
            beat_gap[i]  = 0;
        end
        run_gather(6, 8'($urandom_range(0, 255)));
`ifdef SA_SEQ_PERF_EN
        check("perf_inst_abort", perf_inst_count, n_done_exp);
        check("perf_busy", perf_busy_cycles, 32'd17);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
